// File: rtl/sram_mem_controller_if.sv
// MEM-stage request/response bundle between the pipeline and sram_mem_controller.
// addr_err is present only when SRAM_MISALIGN_CHK_EN is defined.
interface sram_mem_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
`ifdef SRAM_MISALIGN_CHK_EN
  logic        addr_err;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready, addr_err
  );
  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready, addr_err
  );
`else
  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );
  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
`endif
endinterface

// File: rtl/sram_mem_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto a 256Kx16 async SRAM as two half accesses plus a settle wait.
// Optional SRAM_MISALIGN_CHK_EN: misaligned requests finish immediately with addr_err instead of touching the SRAM.
module sram_mem_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_mem_controller_if.slave  bus,
  output logic [17:0]           sram_addr,
  output logic [15:0]           sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [15:0]           sram_dq_in,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOW  = 3'd1;
  localparam logic [2:0] S_HIGH = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  logic [2:0]  state;
  logic        is_write;
  logic [16:0] waddr;
  logic [31:0] wdata;
  logic [31:0] rdata_buf;
  logic [3:0]  wait_cnt;

  logic        request;
  logic        misaligned;
  logic [31:0] offset;
  logic [16:0] req_waddr;
  logic        unused_offset;

  assign request   = bus.rd_en | bus.wr_en;
  // Out-of-window addresses simply wrap into the 17-bit word space.
  assign offset    = bus.address - BASE_ADDR;
  assign req_waddr = offset[18:2];
  assign unused_offset = ^{offset[31:19], offset[1:0]};

`ifdef SRAM_MISALIGN_CHK_EN
  logic err_q;

  assign misaligned   = bus.address[1:0] != 2'b00;
  assign bus.addr_err = (state == S_DONE) && err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE) begin
      err_q <= request & misaligned;
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // The SRAM pins are registers on the async reset, so rst forces we_n high and oe low without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      is_write      <= 1'b0;
      waddr         <= '0;
      wdata         <= '0;
      rdata_buf     <= '0;
      wait_cnt      <= '0;
      bus.read_data <= '0;
      sram_addr     <= '0;
      sram_dq_out   <= '0;
      sram_dq_oe    <= 1'b0;
      sram_we_n     <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (request) begin
            is_write <= bus.wr_en;
            waddr    <= req_waddr;
            wdata    <= bus.write_data;
            if (misaligned) begin
              state <= S_DONE;
            end else begin
              state       <= S_LOW;
              sram_addr   <= {req_waddr, 1'b0};
              sram_dq_out <= bus.write_data[15:0];
              sram_dq_oe  <= bus.wr_en;
              sram_we_n   <= ~bus.wr_en;
            end
          end
        end

        S_LOW: begin
          if (!is_write) begin
            rdata_buf[15:0] <= sram_dq_in;
          end
          state       <= S_HIGH;
          sram_addr   <= {waddr, 1'b1};
          sram_dq_out <= wdata[31:16];
          sram_dq_oe  <= is_write;
          sram_we_n   <= ~is_write;
        end

        S_HIGH: begin
          if (!is_write) begin
            rdata_buf[31:16] <= sram_dq_in;
          end
          state      <= S_WAIT;
          sram_dq_oe <= 1'b0;
          sram_we_n  <= 1'b1;
        end

        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            state    <= S_DONE;
            if (!is_write) begin
              bus.read_data <= rdata_buf;
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bus.ready = 1'b0;
    case (state)
      S_IDLE:  bus.ready = ~request;
      S_DONE:  bus.ready = 1'b1;
      default: bus.ready = 1'b0;
    endcase
  end

  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;
  assign sram_ce_n = 1'b0;
  assign sram_oe_n = 1'b0;

endmodule
